// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory read, one-entry output buffer, redirect support.
// Build option FETCH_MISALIGN_TRAP_EN: misaligned redirect targets park the unit in FAULT.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misaligned,
  output logic [2:0]  state_dbg
);

  // Handshakes: a memory request is accepted in a cycle with mem_req & mem_gnt; an
  // instruction is consumed in a cycle with instr_valid & instr_ready, and instr,
  // instr_pc and instr_valid do not change until that happens (or a redirect flushes).
`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {
    S_REQ = 3'd0, S_WAIT = 3'd1, S_HOLD = 3'd2, S_DROP = 3'd3, S_FAULT = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_REQ = 3'd0, S_WAIT = 3'd1, S_HOLD = 3'd2, S_DROP = 3'd3
  } state_t;
`endif

  state_t      state, state_n, redirect_state;
  logic [31:0] pc, pc_n, instr_n, instr_pc_n, target;
  logic        valid_n;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis_q, mis_n, pending, pending_n, target_bad;
  assign target     = redirect_pc;
  assign target_bad = |redirect_pc[1:0];
  assign misaligned = mis_q;
`else
  logic unused_lsbs;
  assign target      = {redirect_pc[31:2], 2'b00};
  assign unused_lsbs = ^redirect_pc[1:0];
  assign misaligned  = 1'b0;
`endif

  assign mem_req   = (state == S_REQ) && !rst;
  assign mem_addr  = pc;
  assign state_dbg = state;

  // Where an aligned redirect lands: DROP whenever a read is still in flight.
  always_comb begin
    redirect_state = S_REQ;
    case (state)
      S_REQ:         redirect_state = mem_gnt ? S_DROP : S_REQ;
      S_WAIT, S_DROP: redirect_state = mem_rvalid ? S_REQ : S_DROP;
`ifdef FETCH_MISALIGN_TRAP_EN
      S_FAULT:       redirect_state = (pending && !mem_rvalid) ? S_DROP : S_REQ;
`endif
      default:       redirect_state = S_REQ;
    endcase
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    instr_n    = instr;
    instr_pc_n = instr_pc;
    valid_n    = instr_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_n      = mis_q;
    pending_n  = pending;
    if (mem_rvalid) pending_n = 1'b0;
    if (mem_req && mem_gnt) pending_n = 1'b1;
`endif
    case (state)
      S_REQ: if (mem_gnt) state_n = S_WAIT;
      S_WAIT: begin
        if (mem_rvalid) begin
          instr_n    = mem_rdata;
          instr_pc_n = pc;
          valid_n    = 1'b1;
          pc_n       = pc + 32'd4;
          state_n    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          valid_n = 1'b0;
          state_n = S_REQ;
        end
      end
      S_DROP: if (mem_rvalid) state_n = S_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
      S_FAULT: state_n = S_FAULT;
`endif
      default: state_n = S_REQ;
    endcase
    if (redirect) begin
      valid_n = 1'b0;
      pc_n    = target;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_n   = target_bad;
      state_n = target_bad ? S_FAULT : redirect_state;
`else
      state_n = redirect_state;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q       <= 1'b0;
      pending     <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= valid_n;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q       <= mis_n;
      pending     <= pending_n;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed sequences, a redirect-target table and a randomized
// run against a transaction-level model of the expected instruction stream.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misaligned;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .misaligned(misaligned), .state_dbg(state_dbg)
  );

  typedef struct {
    logic [31:0] target;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_mis;
    logic        addr_valid;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // random-phase model state
  logic [31:0] exp_pc, busy_addr, rtarget, prev_instr, prev_pc;
  logic        exp_mis, busy, prev_hold, bad;
  int          cnt, delivered;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'h0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
  endtask

  // Starts in REQ at addr; ends in HOLD with the instruction presented.
  task automatic fetch_one(input logic [31:0] addr);
    chk("fetch_req", mem_req, 1);
    chk("fetch_addr", mem_addr, addr);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("wait_no_req", mem_req, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = word_of(addr);
    tick();
    mem_rvalid = 1'b0;
    chk("latency_valid", instr_valid, 1);
    chk("instr_pc", instr_pc, addr);
    chk("instr_data", instr, word_of(addr));
  endtask

  task automatic consume();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  initial begin
`ifdef FETCH_MISALIGN_TRAP_EN
    vecs[0] = '{32'h0000_0200, 1'b1, 32'h0000_0200, 1'b0, 1'b1};
    vecs[1] = '{32'h0000_0202, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0204, 1'b1, 32'h0000_0204, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0007, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[4] = '{32'h0000_0010, 1'b1, 32'h0000_0010, 1'b0, 1'b1};
`else
    vecs[0] = '{32'h0000_0200, 1'b1, 32'h0000_0200, 1'b0, 1'b1};
    vecs[1] = '{32'h0000_0202, 1'b1, 32'h0000_0200, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0204, 1'b1, 32'h0000_0204, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0007, 1'b1, 32'h0000_0004, 1'b0, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1};
`endif
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_misaligned", misaligned, 0);
    rst = 1'b0;
    #1;

    // back-to-back fetches from RESET_PC
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    while (exp_q.size() > 0) begin
      fetch_one(exp_q.pop_front());
      consume();
      chk("consumed_valid", instr_valid, 0);
    end

    // decoder stall keeps the buffer stable and memory idle
    fetch_one(32'h10C);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", instr_valid, 1);
      chk("stall_pc", instr_pc, 32'h10C);
      chk("stall_instr", instr, word_of(32'h10C));
      chk("stall_no_req", mem_req, 0);
    end
    consume();
    chk("after_ready_req", mem_req, 1);
    chk("after_ready_addr", mem_addr, 32'h110);

    // redirect while waiting: late data must be discarded
    mem_gnt = 1'b1;
    tick();
    mem_gnt     = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    chk("drop_valid", instr_valid, 0);
    chk("drop_no_req", mem_req, 0);
    tick();
    chk("drop_still_no_req", mem_req, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("stale_not_valid", instr_valid, 0);
    fetch_one(32'h200);
    consume();

    // redirect coinciding with rvalid
    mem_gnt = 1'b1;
    tick();
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b1;
    mem_rdata   = 32'h1111_1111;
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    tick();
    mem_rvalid = 1'b0;
    redirect   = 1'b0;
    chk("same_cycle_valid", instr_valid, 0);
    chk("same_cycle_req", mem_req, 1);
    chk("same_cycle_addr", mem_addr, 32'h300);

    // PC wrap
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    fetch_one(32'hFFFF_FFFC);
    consume();
    chk("wrap_addr", mem_addr, 32'h0);

    // redirect together with a consuming handshake, then without
    fetch_one(32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h400;
    instr_ready = 1'b1;
    tick();
    redirect    = 1'b0;
    instr_ready = 1'b0;
    chk("redir_hs_valid", instr_valid, 0);
    chk("redir_hs_addr", mem_addr, 32'h400);
    fetch_one(32'h400);
    redirect    = 1'b1;
    redirect_pc = 32'h500;
    tick();
    redirect = 1'b0;
    chk("redir_hold_valid", instr_valid, 0);
    chk("redir_hold_req", mem_req, 1);
    chk("redir_hold_addr", mem_addr, 32'h500);

    // reset mid-transaction
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst     = 1'b1;
    tick();
    chk("midrst_req", mem_req, 0);
    chk("midrst_valid", instr_valid, 0);
    rst = 1'b0;
    #1;
    chk("midrst_restart_req", mem_req, 1);
    chk("midrst_restart_addr", mem_addr, 32'h100);

    // redirect-target table, memory never granting
    for (int i = 0; i < 5; i++) begin
      redirect    = 1'b1;
      redirect_pc = vecs[i].target;
      tick();
      redirect = 1'b0;
      chk("tbl_req", mem_req, vecs[i].exp_req);
      chk("tbl_mis", misaligned, vecs[i].exp_mis);
      if (vecs[i].addr_valid) chk("tbl_addr", mem_addr, vecs[i].exp_addr);
    end

    // randomized run against the stream model
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    exp_pc    = 32'h100;
    exp_mis   = 1'b0;
    busy      = 1'b0;
    busy_addr = 32'h0;
    cnt       = 0;
    delivered = 0;
    prev_hold = 1'b0;
    prev_instr = 32'h0;
    prev_pc   = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_mis", misaligned, exp_mis);
      if (exp_mis) begin
        chk("rnd_fault_req", mem_req, 0);
        chk("rnd_fault_valid", instr_valid, 0);
      end
      if (instr_valid) chk("rnd_data", instr, word_of(instr_pc));
      if (prev_hold) begin
        chk("rnd_hold_valid", instr_valid, 1);
        chk("rnd_hold_instr", instr, prev_instr);
        chk("rnd_hold_pc", instr_pc, prev_pc);
      end
      chk("rnd_one_outstanding", mem_req & busy, 0);

      mem_gnt     = ($urandom_range(0, 1) == 1);
      instr_ready = ($urandom_range(0, 2) != 0);
      redirect    = ($urandom_range(0, 9) == 0);
      rtarget     = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : 32'($urandom_range(0, 4095));
`ifdef FETCH_MISALIGN_TRAP_EN
      if ($urandom_range(0, 3) != 0) rtarget[1:0] = 2'b00;
`endif
      redirect_pc = rtarget;
      mem_rvalid  = 1'b0;
      mem_rdata   = $urandom;
      if (busy) begin
        if (cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = word_of(busy_addr);
        end else begin
          cnt--;
        end
      end
      #1;

      if (mem_rvalid) busy = 1'b0;
      if (mem_req && mem_gnt) begin
        chk("rnd_grant_addr", mem_addr, exp_pc);
        busy      = 1'b1;
        busy_addr = mem_addr;
        cnt       = $urandom_range(0, 3);
      end
      if (instr_valid && instr_ready) begin
        chk("rnd_order", instr_pc, exp_pc);
        exp_pc = instr_pc + 32'd4;
        delivered++;
      end
      if (redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        bad     = (rtarget[1:0] != 2'b00);
        exp_mis = bad;
        exp_pc  = rtarget;
`else
        bad     = 1'b0;
        exp_pc  = rtarget & 32'hFFFF_FFFC;
`endif
      end
      prev_hold  = instr_valid && !instr_ready && !redirect;
      prev_instr = instr;
      prev_pc    = instr_pc;
      tick();
    end
    idle_inputs();
    chk("rnd_progress", (delivered >= 30), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
